// File: rtl/data_sram_slave_if.sv
// CPU data-SRAM request/response bundle: the CPU top drives the request, the RAM slave returns rdata.
interface data_sram_slave_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_slave.sv
// Single-port byte-lane-writable data RAM with 1-cycle registered read and out-of-window flag.
// Optional access statistics (rd_cnt/wr_cnt) are enabled by defining DATA_SRAM_STAT_EN.
module data_sram_slave #(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  data_sram_slave_if.slave   bus,
  output logic               range_err
`ifdef DATA_SRAM_STAT_EN
  ,
  output logic [31:0]        rd_cnt,
  output logic [31:0]        wr_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              is_write;
  logic [31:0]       merged;

  assign idx      = ADDR_W'((bus.data_sram_addr - BASE_ADDR) >> 2);
  assign in_range = (bus.data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign is_write = (bus.data_sram_wen != 4'b0000);

  // For reads (wen=0) merged is simply the stored word, so one path serves both.
  always_comb begin
    merged = mem[idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (bus.data_sram_wen[i]) merged[8*i +: 8] = bus.data_sram_wdata[8*i +: 8];
    end
  end

  // Kept separate from the reset-bearing registers so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && bus.data_sram_en && in_range && is_write) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_sram_rdata <= '0;
      range_err           <= 1'b0;
    end else begin
      range_err <= 1'b0;
      if (bus.data_sram_en) begin
        if (in_range) begin
          bus.data_sram_rdata <= merged;
        end else begin
          bus.data_sram_rdata <= '0;
          range_err           <= 1'b1;
        end
      end
    end
  end

`ifdef DATA_SRAM_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (bus.data_sram_en && in_range) begin
      if (is_write) wr_cnt <= wr_cnt + 32'd1;
      else          rd_cnt <= rd_cnt + 32'd1;
    end
  end
`endif

endmodule
